// File: rtl/ex_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Retires BITS_PER_CYCLE bits per cycle and stalls the pipeline while busy.
module ex_mdu #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       reg1_i,
    input  logic [XLEN-1:0]       reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    output logic                  stallreq_o,
    output logic                  done_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o
);
    localparam int ITERS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] wd_q;
    logic                  wreg_q;
    logic [CW-1:0]         cnt;
    logic [2*XLEN-1:0]     acc, acc_nx;     // mul: product; div: {remainder, quotient}
    logic [2*XLEN-1:0]     mcand, mcand_nx; // left-shifting multiplicand
    logic [XLEN-1:0]       opb, opb_nx;     // mul: right-shifting multiplier; div: divisor
    logic                  neg_q, neg_r;
    logic [XLEN-1:0]       wdata_q;

    // Operand decode in IDLE
    logic            is_div, sgn1_en, sgn2_en, s1, s2;
    logic [XLEN-1:0] mag1, mag2, spec_res;
    logic            div_zero, div_ovf, special;

    always_comb begin
        is_div   = op_i[2];
        sgn1_en  = is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
        sgn2_en  = is_div ? ~op_i[0] : ~op_i[1];
        s1       = reg1_i[XLEN-1] & sgn1_en;
        s2       = reg2_i[XLEN-1] & sgn2_en;
        mag1     = s1 ? -reg1_i : reg1_i;
        mag2     = s2 ? -reg2_i : reg2_i;
        div_zero = is_div && (reg2_i == '0);
        div_ovf  = is_div && ~op_i[0] && (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) && (reg2_i == '1);
        special  = div_zero | div_ovf;
        if (div_zero) spec_res = op_i[1] ? reg1_i : '1;
        else          spec_res = op_i[1] ? '0 : reg1_i;
    end

    // One CALC cycle worth of shift-add / restoring-divide steps
    logic [XLEN:0]   rem_t;
    logic [XLEN-1:0] q_t;

    always_comb begin
        acc_nx   = acc;
        mcand_nx = mcand;
        opb_nx   = opb;
        rem_t    = '0;
        q_t      = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                rem_t = {acc_nx[2*XLEN-1:XLEN], acc_nx[XLEN-1]};
                q_t   = {acc_nx[XLEN-2:0], 1'b0};
                if (rem_t >= {1'b0, opb}) begin
                    rem_t  = rem_t - {1'b0, opb};
                    q_t[0] = 1'b1;
                end
                acc_nx = {rem_t[XLEN-1:0], q_t};
            end else begin
                if (opb_nx[0]) acc_nx = acc_nx + mcand_nx;
                mcand_nx = mcand_nx << 1;
                opb_nx   = opb_nx >> 1;
            end
        end
    end

    // Sign fix-up and result select on the final iteration
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res;

    always_comb begin
        prod = neg_q ? -acc_nx : acc_nx;
        quo  = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        rem  = neg_r ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:        res = quo;
            default:               res = rem;
        endcase
    end

    always_comb begin
        state_nx = state;
        if (flush_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (start_i) state_nx = special ? DONE : CALC;
                CALC: if (cnt == CW'(1)) state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            opb     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start_i && !flush_i) begin
                op_q   <= op_i;
                wd_q   <= wd_i;
                wreg_q <= wreg_i;
                neg_q  <= s1 ^ s2;
                neg_r  <= s1;
                cnt    <= CW'(ITERS);
                opb    <= mag2;
                if (is_div) begin
                    acc   <= {{XLEN{1'b0}}, mag1};
                    mcand <= '0;
                end else begin
                    acc   <= '0;
                    mcand <= {{XLEN{1'b0}}, mag1};
                end
                if (special) wdata_q <= spec_res;
            end else if (state == CALC) begin
                acc   <= acc_nx;
                mcand <= mcand_nx;
                opb   <= opb_nx;
                cnt   <= cnt - CW'(1);
                if (cnt == CW'(1)) wdata_q <= res;
            end
        end
    end

    // Held low during reset so a pending start_i cannot stall a resetting pipe
    assign stallreq_o = rst && !flush_i && ((state == IDLE && start_i) || state == CALC);
    assign done_o     = (state == DONE) && !flush_i;
    assign wdata_o    = wdata_q;
    assign wd_o       = wd_q;
    assign wreg_o     = wreg_q && done_o;
endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: three instances (32/1, 32/4, 64/4) fed directed
// vectors; per-instance monitors pop expected results on each done_o pulse.
module tb_ex_mdu;
    logic        clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic [2:0]  op = '0;
    logic [63:0] r1 = '0, r2 = '0;
    logic [4:0]  wd = '0;
    logic        wreg = 1'b0;
    logic        start32 = 1'b0, start4 = 1'b0, start64 = 1'b0;

    logic        stall32, done32, wreg32, stall4, done4, wreg4, stall64, done64, wreg64;
    logic [31:0] wdata32, wdata4;
    logic [63:0] wdata64;
    logic [4:0]  wd32, wd4, wd64;

    int cyc = 0, n_cmp = 0, n_bad = 0;

    typedef struct { logic [63:0] data; logic [4:0] wd; int cyc; } exp_t;
    exp_t q32[$], q4[$], q64[$];
    exp_t e32, e4, e64;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ex_mdu #(.XLEN(32), .BITS_PER_CYCLE(1), .REG_ADDR_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush_i(flush), .start_i(start32), .op_i(op),
        .reg1_i(r1[31:0]), .reg2_i(r2[31:0]), .wd_i(wd), .wreg_i(wreg),
        .stallreq_o(stall32), .done_o(done32), .wdata_o(wdata32), .wd_o(wd32), .wreg_o(wreg32));
    ex_mdu #(.XLEN(32), .BITS_PER_CYCLE(4), .REG_ADDR_W(5)) dut4 (
        .clk(clk), .rst(rst), .flush_i(flush), .start_i(start4), .op_i(op),
        .reg1_i(r1[31:0]), .reg2_i(r2[31:0]), .wd_i(wd), .wreg_i(wreg),
        .stallreq_o(stall4), .done_o(done4), .wdata_o(wdata4), .wd_o(wd4), .wreg_o(wreg4));
    ex_mdu #(.XLEN(64), .BITS_PER_CYCLE(4), .REG_ADDR_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush_i(flush), .start_i(start64), .op_i(op),
        .reg1_i(r1), .reg2_i(r2), .wd_i(wd), .wreg_i(wreg),
        .stallreq_o(stall64), .done_o(done64), .wdata_o(wdata64), .wd_o(wd64), .wreg_o(wreg64));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        n_cmp++; n_bad++;
        $display("FAIL %s unexpected done_o: got 1 want 0 (cycle %0d)", nm, cyc);
    endtask

    // Monitors
    always begin
        @(negedge clk); #1;
        if (done32) begin
            if (q32.size() == 0) unexpected("d32");
            else begin
                e32 = q32.pop_front();
                chk("d32 wdata", {32'b0, wdata32}, e32.data);
                chk("d32 wd", wd32, e32.wd);
                chk("d32 wreg", wreg32, 1);
                chk("d32 done cycle", cyc, e32.cyc);
            end
        end
    end
    always begin
        @(negedge clk); #1;
        if (done4) begin
            if (q4.size() == 0) unexpected("d4");
            else begin
                e4 = q4.pop_front();
                chk("d4 wdata", {32'b0, wdata4}, e4.data);
                chk("d4 wreg", wreg4, 1);
                chk("d4 done cycle", cyc, e4.cyc);
            end
        end
    end
    always begin
        @(negedge clk); #1;
        if (done64) begin
            if (q64.size() == 0) unexpected("d64");
            else begin
                e64 = q64.pop_front();
                chk("d64 wdata", wdata64, e64.data);
                chk("d64 wreg", wreg64, 1);
                chk("d64 done cycle", cyc, e64.cyc);
            end
        end
    end

    task automatic drive(input int d, input logic s);
        case (d)
            0: start32 = s;
            1: start4  = s;
            default: start64 = s;
        endcase
    endtask

    function automatic logic stall_of(input int d);
        case (d)
            0: return stall32;
            1: return stall4;
            default: return stall64;
        endcase
    endfunction

    function automatic logic done_of(input int d);
        case (d)
            0: return done32;
            1: return done4;
            default: return done64;
        endcase
    endfunction

    function automatic int qsz(input int d);
        case (d)
            0: return q32.size();
            1: return q4.size();
            default: return q64.size();
        endcase
    endfunction

    task automatic push(input int d, input exp_t x);
        case (d)
            0: q32.push_back(x);
            1: q4.push_back(x);
            default: q64.push_back(x);
        endcase
    endtask

    // Called on/just after a negedge; issues one op and waits for its result.
    task automatic run(input string nm, input int d, input logic [2:0] o,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] w,
                       input logic [63:0] e, input int lat);
        int   bad;
        exp_t x;
        op = o; r1 = a; r2 = b; wd = w; wreg = 1'b1;
        drive(d, 1'b1);
        x.data = e; x.wd = w; x.cyc = cyc + lat;
        push(d, x);
        bad = 0;
        for (int k = 0; k < lat; k++) begin
            #1;
            if (stall_of(d) !== 1'b1 || done_of(d) !== 1'b0) bad++;
            @(negedge clk);
            drive(d, 1'b0);
            r1 = ~a; r2 = ~b;   // operands must already be captured
        end
        #1;
        chk({nm, " stall window errors"}, bad, 0);
        chk({nm, " stall low at done"}, stall_of(d), 0);
        for (int i = 0; i < 200 && qsz(d) != 0; i++) @(posedge clk);
        chk({nm, " result drained"}, qsz(d), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t, pulses;
        // Reset state, with start_i asserted to show stall stays low
        start32 = 1'b1;
        #12;
        chk("reset done", done32, 0);
        chk("reset wdata", wdata32, 0);
        chk("reset wd", wd32, 0);
        chk("reset wreg", wreg32, 0);
        chk("reset stall", stall32, 0);
        start32 = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        run("MUL", 0, 3'b000, 64'h7, 64'hFFFFFFFD, 5'd3, 64'hFFFFFFEB, 33);
        run("MULHU", 0, 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd4, 64'hFFFFFFFE, 33);
        run("MULH", 0, 3'b001, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd5, 64'h0, 33);
        run("MULHSU", 0, 3'b010, 64'hFFFFFFFF, 64'h2, 5'd6, 64'hFFFFFFFF, 33);
        run("DIV", 0, 3'b100, 64'hFFFFFFF9, 64'h2, 5'd7, 64'hFFFFFFFD, 33);
        run("REM", 0, 3'b110, 64'hFFFFFFF9, 64'h2, 5'd8, 64'hFFFFFFFF, 33);
        run("DIVU", 0, 3'b101, 64'd100, 64'd7, 5'd9, 64'd14, 33);
        run("REMU", 0, 3'b111, 64'd100, 64'd7, 5'd10, 64'd2, 33);
        run("DIVU by 0", 0, 3'b101, 64'd5, 64'd0, 5'd11, 64'hFFFFFFFF, 1);
        run("REMU by 0", 0, 3'b111, 64'd5, 64'd0, 5'd12, 64'd5, 1);
        run("DIV ovf", 0, 3'b100, 64'h80000000, 64'hFFFFFFFF, 5'd13, 64'h80000000, 1);
        run("REM ovf", 0, 3'b110, 64'h80000000, 64'hFFFFFFFF, 5'd14, 64'h0, 1);

        // Flush a DIV at T+10; MUL issued at T+11 must finish at T+44
        t = cyc; op = 3'b100; r1 = 64'd100; r2 = 64'd7; wd = 5'd15; start32 = 1'b1;
        @(negedge clk); start32 = 1'b0;
        while (cyc < t + 10) @(negedge clk);
        flush = 1'b1; #1;
        chk("flush stall", stall32, 0);
        chk("flush done", done32, 0);
        @(negedge clk); flush = 1'b0; #1;
        chk("post-flush idle stall", stall32, 0);
        chk("post-flush cycle", cyc, t + 11);
        run("MUL after flush", 0, 3'b000, 64'h7, 64'hFFFFFFFD, 5'd16, 64'hFFFFFFEB, 33);

        // start_i held through DONE: one pulse, no restart
        op = 3'b101; r1 = 64'd5; r2 = 64'd0; wd = 5'd17; start32 = 1'b1;
        q32.push_back('{64'hFFFFFFFF, 5'd17, cyc + 1});
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (done32) pulses++;
            if (k == 1) chk("hold: stall in DONE", stall32, 0);
            if (k == 2) chk("hold: stall after DONE", stall32, 0);
            @(negedge clk);
            if (k == 1) start32 = 1'b0;
        end
        chk("hold: done pulses", pulses, 1);

        // Async reset at T+5 of a MUL
        op = 3'b000; r1 = 64'h7; r2 = 64'hFFFFFFFD; wd = 5'd18; start32 = 1'b1;
        @(negedge clk); start32 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0; #1;
        chk("async rst done", done32, 0);
        chk("async rst wdata", wdata32, 0);
        chk("async rst wd", wd32, 0);
        chk("async rst wreg", wreg32, 0);
        chk("async rst stall", stall32, 0);
        @(negedge clk); rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (done32) pulses++;
        end
        chk("no done after reset abort", pulses, 0);
        @(negedge clk);

        run("MUL bpc4", 1, 3'b000, 64'h7, 64'hFFFFFFFD, 5'd19, 64'hFFFFFFEB, 9);
        run("DIV bpc4", 1, 3'b100, 64'hFFFFFFF9, 64'h2, 5'd20, 64'hFFFFFFFD, 9);
        run("MUL x64", 2, 3'b000, 64'h7, 64'hFFFFFFFFFFFFFFFD, 5'd21, 64'hFFFFFFFFFFFFFFEB, 17);
        run("DIV x64", 2, 3'b100, 64'hFFFFFFFFFFFFFFF9, 64'h2, 5'd22, 64'hFFFFFFFFFFFFFFFD, 17);
        run("MULHU x64", 2, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd23,
            64'hFFFFFFFFFFFFFFFE, 17);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
